// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the burst reader and the RAM it reads from.
package ram_burst_reader_pkg;

   localparam int AW_DEF = 14;
   localparam int DW_DEF = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Number of words held in a two-entry FIFO, from its flags.
   function automatic logic [1:0] fifo_level(input logic full, input logic empty);
      if (full)
         return 2'd2;
      else if (empty)
         return 2'd0;
      else
         return 2'd1;
   endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// RAM read port plus valid/ready output stream of the burst reader.
interface ram_burst_reader_if
   import ram_burst_reader_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;

   modport master (
      output ram_we,
      output ram_addr,
      input  ram_dout,
      output m_valid,
      input  m_ready,
      output m_data
   );

   modport slave (
      input  ram_we,
      input  ram_addr,
      output ram_dout,
      input  m_valid,
      output m_ready,
      input  m_data
   );
endinterface

// File: rtl/lr3264.sv
// Single-port synchronous RAM: read data appears one cycle after the address.
module lr3264
   import ram_burst_reader_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem [2**AW];

   // Write-through-free RAM: read returns the old contents on a write cycle.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= din;
      dout <= mem[addr];
   end
endmodule

// File: rtl/ram_burst_reader_skid_fifo2.sv
// Two-entry output FIFO; dout is the head word whenever not empty.
module skid_fifo2
   import ram_burst_reader_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   logic [DW-1:0] entry0;
   logic [DW-1:0] entry1;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = rd_ptr ? entry1 : entry0;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         entry0 <= '0;
         entry1 <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            if (wr_ptr)
               entry1 <= din;
            else
               entry0 <= din;
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ram_burst_reader.sv
// Reads len consecutive RAM words from base_addr and streams them out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; an accepted start issues the first read
// ST_READ  | issuing remaining reads while FIFO + in-flight < 2
// ST_DRAIN | all reads issued, waiting for the last word to be accepted
// ST_DONE  | one-cycle done pulse, then back to idle
module ram_burst_reader
   import ram_burst_reader_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   ram_burst_reader_if.master bus
);
   logic [1:0]    state;
   logic [AW-1:0] next_addr;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] rd_left;
   logic [AW-1:0] acc_left;
   logic          inflight;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic [1:0]    level;
   logic          pop;
   logic          issue_first;
   logic          issue_rd;
   logic          room;

   assign level = fifo_level(fifo_full, fifo_empty);
   assign pop   = !fifo_empty && bus.m_ready;

   // Occupancy counts the word leaving this cycle as gone, so a steady
   // m_ready sustains one word per cycle.
   assign room = (({1'b0, level} - {2'b0, pop} + {2'b0, inflight}) < 3'd2);

   // The first read goes out in the start cycle itself so the first word
   // reaches the output two cycles after start.
   assign issue_first = reset && (state == ST_IDLE) && start && (len != '0);
   assign issue_rd    = (state == ST_READ) && (rd_left != '0) && room;

   assign bus.ram_we   = 1'b0;
   assign bus.ram_addr = issue_first ? base_addr :
                         issue_rd    ? next_addr : last_addr;
   assign bus.m_valid  = !fifo_empty;
   assign bus.m_data   = fifo_dout;
   assign busy         = (state == ST_READ) || (state == ST_DRAIN);
   assign done         = (state == ST_DONE);

   // Burst sequencing, address generation and read/accept countdowns.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         next_addr <= '0;
         last_addr <= '0;
         rd_left   <= '0;
         acc_left  <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= issue_first || issue_rd;
         if (pop)
            acc_left <= acc_left - 1'b1;
         if (issue_rd) begin
            last_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            rd_left   <= rd_left - 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     state <= ST_DONE;
                  end else begin
                     state     <= ST_READ;
                     last_addr <= base_addr;
                     next_addr <= base_addr + 1'b1;
                     rd_left   <= len - 1'b1;
                     acc_left  <= len;
                  end
               end
            end
            ST_READ: begin
               if ((rd_left == '0) || (issue_rd && (rd_left == {{(AW-1){1'b0}}, 1'b1})))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && (acc_left == {{(AW-1){1'b0}}, 1'b1}))
                  state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   skid_fifo2 #(.DW(DW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .pop   (pop),
      .din   (bus.ram_dout),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule
